// File: rtl/mux_reg_pkg.sv
// Shared definitions for the registered N-way operand mux stage.
package mux_reg_pkg;

  localparam int unsigned OP_W = 2;

  localparam logic [OP_W-1:0] OP_HOLD  = 2'b00;
  localparam logic [OP_W-1:0] OP_LOAD  = 2'b01;
  localparam logic [OP_W-1:0] OP_CLEAR = 2'b10;
  localparam logic [OP_W-1:0] OP_RSVD  = 2'b11;

  localparam int unsigned    DEF_WIDTH     = 16;
  localparam logic [DEF_WIDTH-1:0] DEF_CLEAR_VAL = 16'h0000;

endpackage

// File: rtl/mux_nway_sel.sv
// Combinational N-way channel select; out-of-range selects yield CLEAR_VAL and raise oor_c.
module mux_nway_sel
  import mux_reg_pkg::*;
#(
  parameter int unsigned     WIDTH     = DEF_WIDTH,
  parameter int unsigned     NUM_IN    = 4,
  parameter int unsigned     SEL_W     = 2,
  parameter logic [WIDTH-1:0] CLEAR_VAL = WIDTH'(DEF_CLEAR_VAL)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        sel_data_c,
  output logic                    oor_c
);

  always_comb begin
    sel_data_c = CLEAR_VAL;
    oor_c      = 1'b1;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_data_c = in_data[k*WIDTH +: WIDTH];
        oor_c      = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_reg_stage.sv
// Registered N-way operand mux with HOLD/LOAD/CLEAR modes, one-entry valid/ready
// output buffer, sticky select-error flag and an accepted-load counter.
module mux_reg_stage
  import mux_reg_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEF_WIDTH,
  parameter int unsigned      NUM_IN    = 4,
  parameter int unsigned      SEL_W     = 2,
  parameter int unsigned      COUNT_W   = 8,
  parameter logic [WIDTH-1:0] CLEAR_VAL = WIDTH'(DEF_CLEAR_VAL)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic [OP_W-1:0]         op,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  output logic [COUNT_W-1:0]      load_count
);

  logic [WIDTH-1:0] sel_data_c;
  logic             oor_c;
  logic             accept_c;
  logic             drain_c;

  mux_nway_sel #(
    .WIDTH     (WIDTH),
    .NUM_IN    (NUM_IN),
    .SEL_W     (SEL_W),
    .CLEAR_VAL (CLEAR_VAL)
  ) u_sel (
    .in_data    (in_data),
    .sel        (sel),
    .sel_data_c (sel_data_c),
    .oor_c      (oor_c)
  );

  // Buffer is free when empty or being drained this cycle, so loads stream at 1/cycle.
  assign in_ready = (op == OP_LOAD) && (!out_valid || out_ready);
  assign accept_c = in_valid && in_ready;
  assign drain_c  = out_valid && out_ready;

  // out_valid encodes EMPTY/FULL; CLEAR discards any pending value without draining it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data   <= CLEAR_VAL;
      out_valid  <= 1'b0;
      sel_err    <= 1'b0;
      load_count <= '0;
    end else if (op == OP_CLEAR) begin
      out_data   <= CLEAR_VAL;
      out_valid  <= 1'b0;
      sel_err    <= 1'b0;
      load_count <= '0;
    end else if (accept_c) begin
      out_data   <= sel_data_c;
      out_valid  <= 1'b1;
      load_count <= load_count + COUNT_W'(1);
      if (oor_c) begin
        sel_err <= 1'b1;
      end
    end else if (drain_c) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_reg_stage.sv
// Directed plus random stimulus on two builds (4 channels/8-bit count, 3 channels/2-bit count).
module tb_mux_reg_stage;
  import mux_reg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] in_data;
  logic [1:0]  sel;
  logic [1:0]  op;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready4, out_valid4, sel_err4;
  logic [15:0] out_data4;
  logic [7:0]  load_count4;
  logic        in_ready3, out_valid3, sel_err3;
  logic [15:0] out_data3;
  logic [1:0]  load_count3;

  int checks = 0;
  int errors = 0;

  // Reference state per build: index 0 = 4-channel, index 1 = 3-channel
  logic [15:0] m_data  [2];
  logic        m_valid [2];
  logic        m_err   [2];
  int          m_cnt   [2];
  int          nin     [2] = '{4, 3};
  int          cw      [2] = '{8, 2};

  localparam logic [63:0] CH = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

  always #5 clk = ~clk;

  mux_reg_stage #(.WIDTH(16), .NUM_IN(4), .SEL_W(2), .COUNT_W(8), .CLEAR_VAL(16'h0000)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel), .op(op),
    .in_valid(in_valid), .in_ready(in_ready4), .out_data(out_data4),
    .out_valid(out_valid4), .out_ready(out_ready), .sel_err(sel_err4),
    .load_count(load_count4)
  );

  mux_reg_stage #(.WIDTH(16), .NUM_IN(3), .SEL_W(2), .COUNT_W(2), .CLEAR_VAL(16'h0000)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[47:0]), .sel(sel), .op(op),
    .in_valid(in_valid), .in_ready(in_ready3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready), .sel_err(sel_err3),
    .load_count(load_count3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear(input int i);
    m_data[i]  = 16'h0000;
    m_valid[i] = 1'b0;
    m_err[i]   = 1'b0;
    m_cnt[i]   = 0;
  endfunction

  task automatic step(input logic rn, input logic [1:0] o, input logic [63:0] d,
                      input logic [1:0] s, input logic iv, input logic ordy);
    logic ready_exp [2];
    rst_n = rn; op = o; in_data = d; sel = s; in_valid = iv; out_ready = ordy;
    for (int i = 0; i < 2; i++)
      ready_exp[i] = (o == OP_LOAD) && (!m_valid[i] || ordy);
    #1;
    chk("in_ready4", 32'(in_ready4), 32'(ready_exp[0]));
    chk("in_ready3", 32'(in_ready3), 32'(ready_exp[1]));
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rn || o == OP_CLEAR) begin
        model_clear(i);
      end else if (iv && ready_exp[i]) begin
        if (int'(s) < nin[i]) m_data[i] = d[int'(s)*16 +: 16];
        else begin
          m_data[i] = 16'h0000;
          m_err[i]  = 1'b1;
        end
        m_valid[i] = 1'b1;
        m_cnt[i]   = (m_cnt[i] + 1) % (1 << cw[i]);
      end else if (m_valid[i] && ordy) begin
        m_valid[i] = 1'b0;
      end
    end
    #1;
    chk("out_data4",   32'(out_data4),   32'(m_data[0]));
    chk("out_valid4",  32'(out_valid4),  32'(m_valid[0]));
    chk("sel_err4",    32'(sel_err4),    32'(m_err[0]));
    chk("load_count4", 32'(load_count4), 32'(m_cnt[0]));
    chk("out_data3",   32'(out_data3),   32'(m_data[1]));
    chk("out_valid3",  32'(out_valid3),  32'(m_valid[1]));
    chk("sel_err3",    32'(sel_err3),    32'(m_err[1]));
    chk("load_count3", 32'(load_count3), 32'(m_cnt[1]));
  endtask

  initial begin
    rst_n = 1'b0; op = OP_HOLD; in_data = '0; sel = '0; in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 2; i++) model_clear(i);
    #2;

    // Reset with arbitrary data inputs
    step(1'b0, OP_HOLD, {$urandom, $urandom}, 2'd1, 1'b1, 1'b1);
    step(1'b0, OP_RSVD, {$urandom, $urandom}, 2'd3, 1'b1, 1'b0);

    // Basic load, then backpressure holds the value
    step(1'b1, OP_LOAD, CH, 2'd2, 1'b1, 1'b0);
    step(1'b1, OP_LOAD, CH, 2'd0, 1'b1, 1'b0);
    // Simultaneous drain and load (sel=3 is out of range on the 3-channel build)
    step(1'b1, OP_LOAD, CH, 2'd3, 1'b1, 1'b1);
    step(1'b1, OP_LOAD, CH, 2'd1, 1'b0, 1'b1);
    // Drain under HOLD keeps data; sticky error survives a valid load
    step(1'b1, OP_LOAD, CH, 2'd1, 1'b1, 1'b0);
    step(1'b1, OP_HOLD, CH, 2'd0, 1'b1, 1'b1);
    step(1'b1, OP_LOAD, CH, 2'd1, 1'b1, 1'b0);
    // CLEAR beats a simultaneous drain and offered load
    step(1'b1, OP_CLEAR, CH, 2'd1, 1'b1, 1'b1);

    // Five streaming loads: 2-bit counter wraps 1,2,3,0,1
    for (int k = 0; k < 5; k++)
      step(1'b1, OP_LOAD, CH, 2'(k), 1'b1, 1'b1);
    // Reset while FULL and stalled
    step(1'b1, OP_LOAD, CH, 2'd2, 1'b1, 1'b0);
    step(1'b0, OP_LOAD, CH, 2'd2, 1'b1, 1'b0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 59) != 0),
           2'($urandom_range(0, 9) < 6 ? 1 : $urandom_range(0, 3)),
           {$urandom, $urandom},
           2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_reg_stage.md
Name: mux_reg_stage

Overview:
- Parametrised successor to the team's 2-way input/clear operand mux.
- Selects one of NUM_IN channels of WIDTH bits and captures it into an output register.
- Supports explicit HOLD/LOAD/CLEAR modes, a single-entry valid/ready output buffer, a sticky select-error flag and an accepted-load counter.
- Sits between operand sources and the ALU register stage of the 16-bit datapath.

Parameters:
- WIDTH, 16, data width per channel and output.
- NUM_IN, 4, number of input channels (>=2).
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN.
- COUNT_W, 8, width of the accepted-load counter.
- CLEAR_VAL, 0 (WIDTH bits), value loaded by CLEAR, by reset and for an out-of-range select.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_data  input  NUM_IN*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  channel select.
- op  input  2  mode: 00 HOLD, 01 LOAD, 10 CLEAR, 11 reserved (behaves as HOLD).
- in_valid  input  1  upstream offers a load.
- in_ready  output  1  stage will accept a LOAD this cycle.
- out_data  output  WIDTH  registered result.
- out_valid  output  1  out_data holds an unconsumed value.
- out_ready  input  1  downstream consumes out_data.
- sel_err  output  1  sticky; an out-of-range select was accepted.
- load_count  output  COUNT_W  number of accepted loads, modulo 2**COUNT_W.

Behaviour:
- Reset and clock:
  - One clock, clk.
  - Reset is synchronous and active-low (rst_n sampled on the rising clk edge).
  - Under reset, all registers take reset values on the next edge: out_data=CLEAR_VAL, out_valid=0, sel_err=0, load_count=0.
  - Reset overrides every other input.
- States (encoded by out_valid): EMPTY (out_valid=0), FULL (out_valid=1).
- in_ready is combinational: in_ready = (op==LOAD) && (!out_valid || out_ready). It does not depend on in_valid.
- accept = in_valid && in_ready. drain = out_valid && out_ready.
- Priority order: reset > CLEAR > accept/drain.
- CLEAR (op==10), on the next edge:
  - out_data=CLEAR_VAL, out_valid=0, sel_err=0, load_count=0.
  - Any pending output is discarded, even if out_ready=1 that cycle; the discarded value does not count as drained.
- LOAD accept, on the next edge (latency 1 cycle from accept to out_valid):
  - out_data = channel[sel], out_valid=1, load_count += 1, wrapping to 0.
- Out-of-range select (sel >= NUM_IN) on accept:
  - out_data=CLEAR_VAL, out_valid=1, sel_err=1, load_count += 1.
  - sel_err stays 1 until CLEAR or reset.
- Transitions:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on drain without accept.
  - FULL stays FULL on drain and accept in the same cycle; the new value replaces the old, so back-to-back throughput is 1 per cycle.
  - FULL with no drain: in_ready=0, out_data is held stable, and in_valid is ignored.
- HOLD or reserved op:
  - No accept; in_ready=0.
  - A drain still clears out_valid.
  - out_data keeps its last value after a drain.
- The sel and in_data values are only relevant in the cycle of an accept.
- Reset in mid-transfer (out_valid=1, out_ready low or high) forces EMPTY; no value is reported drained.

Decomposition:
- Shared package mux_reg_pkg:
  - op encodings OP_HOLD=2'b00, OP_LOAD=2'b01, OP_CLEAR=2'b10, OP_RSVD=2'b11.
  - Default CLEAR_VAL constant.
- One combinational sub-module, mux_nway_sel (parameters WIDTH, NUM_IN, SEL_W):
  - Outputs the selected channel plus an out-of-range flag.
  - Out-of-range forces CLEAR_VAL.
- mux_reg_stage holds the output register, the EMPTY/FULL control, sel_err and load_count.

Test Plan:
- Reset: hold rst_n=0 for 2 clocks with arbitrary inputs -> out_data=0x0000, out_valid=0, sel_err=0, load_count=0, in_ready=0 while op!=LOAD.
- Basic load: channels = {0x1111, 0x2222, 0x3333, 0x4444}, op=LOAD, sel=2, in_valid=1, out_ready=0 -> next cycle out_data=0x3333, out_valid=1, load_count=1. Then in_ready=0, and a second in_valid with sel=0 leaves out_data=0x3333.
- Backpressure then simultaneous: FULL with 0x3333; set out_ready=1, sel=3, in_valid=1 -> next cycle out_data=0x4444, out_valid=1, load_count=2. Then in_valid=0 -> out_valid=0 and out_data still 0x4444.
- Out-of-range select: build with NUM_IN=3, SEL_W=2, sel=3, accept -> out_data=0x0000, out_valid=1, sel_err=1. A later valid load with sel=1 keeps sel_err=1; CLEAR -> sel_err=0, load_count=0, out_valid=0.
- CLEAR priority: FULL with 0x2222, op=CLEAR, in_valid=1, out_ready=1 -> next cycle out_data=0x0000, out_valid=0, load_count=0, no accept.
- Counter wrap and mid-operation reset: COUNT_W=2, 5 accepted loads -> load_count sequence 1,2,3,0,1. Then drive rst_n=0 while FULL with out_ready=0 -> next cycle out_valid=0, out_data=0x0000.
